// File: rtl/sin_dds_if.sv
// Sine DDS control/sample bundle: frequency/phase control towards the generator, samples back.
// Latency: none (wires only).
// Backpressure: dout_valid/dout_ready handshake; the generator holds everything while stalled.
// Optional: SIN_DDS_COS_EN adds the quadrature cos_out sample.
interface sin_dds_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 8
);
  logic                en;
  logic                freq_we;
  logic [PHASE_W-1:0]  freq_word;
  logic                phase_clr;
  logic signed [OUT_W:0] dout;
  logic                dout_valid;
  logic                dout_ready;
`ifdef SIN_DDS_COS_EN
  logic signed [OUT_W:0] cos_out;

  modport master (
    output en, freq_we, freq_word, phase_clr, dout_ready,
    input  dout, dout_valid, cos_out
  );
  modport slave (
    input  en, freq_we, freq_word, phase_clr, dout_ready,
    output dout, dout_valid, cos_out
  );
`else
  modport master (
    output en, freq_we, freq_word, phase_clr, dout_ready,
    input  dout, dout_valid
  );
  modport slave (
    input  en, freq_we, freq_word, phase_clr, dout_ready,
    output dout, dout_valid
  );
`endif
endinterface

// File: rtl/sin_dds_gen.sv
// DDS sine generator: phase accumulator -> folded quarter-wave ROM -> signed full-wave samples.
// Latency: 2 clk from accumulator issue to dout, 1 sample/clk.
// Backpressure: dout_valid & ~dout_ready freezes every stage; only the frequency load still lands.
// Optional: SIN_DDS_COS_EN adds a quadrature cos_out aligned with dout.
module sin_dds_gen #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 8
) (
  input logic      clk,
  input logic      rst_n,
  sin_dds_if.slave bus
);
  localparam int LUT_N = 2 ** LUT_AW;
  // Only quadrant + ROM index bits of the phase travel down the pipe.
  localparam int TOP_W = LUT_AW + 2;

  // Quarter-wave table value, evaluated at elaboration time.
  function automatic logic [OUT_W-1:0] rom_val(input int i);
    real a;
    a = (2.0 ** OUT_W - 1.0) * $sin(1.5707963267948966 * real'(i) / real'(LUT_N - 1));
    return OUT_W'($rtoi(a + 0.5));
  endfunction

  // Odd quadrants read the table backwards.
  function automatic logic [LUT_AW-1:0] fold_addr(input logic [LUT_AW:0] ph);
    return ph[LUT_AW] ? ~ph[LUT_AW-1:0] : ph[LUT_AW-1:0];
  endfunction

  // Zero-extend the magnitude, then negate for the lower half-wave (-0 stays 0).
  function automatic logic signed [OUT_W:0] apply_sign(input logic neg, input logic [OUT_W-1:0] mag);
    logic signed [OUT_W:0] s;
    s = $signed({1'b0, mag});
    return neg ? -s : s;
  endfunction

  logic [OUT_W-1:0] rom [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
    assign rom[gi] = rom_val(gi);
  end

  logic [PHASE_W-1:0]    acc;
  logic [PHASE_W-1:0]    freq;
  logic [TOP_W-1:0]      p0;
  logic                  v0;
  logic [OUT_W-1:0]      mag;
  logic                  neg;
  logic                  v1;
  logic signed [OUT_W:0] dout_r;
  logic                  out_vld;
  logic                  stall;

  assign stall          = out_vld & ~bus.dout_ready;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = out_vld;

  // Frequency register: loads even while the pipe is frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freq <= '0;
    end else if (bus.freq_we) begin
      freq <= bus.freq_word;
    end
  end

  // Stage 0: issue the current phase and advance; a clear beats the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      p0  <= '0;
      v0  <= 1'b0;
    end else if (!stall) begin
      v0 <= bus.en;
      if (bus.en) begin
        p0 <= bus.phase_clr ? '0 : acc[PHASE_W-1 -: TOP_W];
      end
      if (bus.phase_clr) begin
        acc <= '0;
      end else if (bus.en) begin
        acc <= acc + freq;
      end
    end
  end

  // Stage 1: quadrant fold and ROM lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag <= '0;
      neg <= 1'b0;
      v1  <= 1'b0;
    end else if (!stall) begin
      mag <= rom[fold_addr(p0[LUT_AW:0])];
      neg <= p0[TOP_W-1];
      v1  <= v0;
    end
  end

  // Stage 2: apply sign and present the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r  <= '0;
      out_vld <= 1'b0;
    end else if (!stall) begin
      dout_r  <= apply_sign(neg, mag);
      out_vld <= v1;
    end
  end

`ifdef SIN_DDS_COS_EN
  // Cosine leads sine by a quarter turn: bump the quadrant field.
  logic [TOP_W-1:0]      p0_c;
  logic [OUT_W-1:0]      mag_c;
  logic                  neg_c;
  logic signed [OUT_W:0] cos_r;

  assign p0_c        = p0 + TOP_W'(LUT_N);
  assign bus.cos_out = cos_r;

  // Second fold/ROM port and sign stage, frozen together with the sine path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_c <= '0;
      neg_c <= 1'b0;
      cos_r <= '0;
    end else if (!stall) begin
      mag_c <= rom[fold_addr(p0_c[LUT_AW:0])];
      neg_c <= p0_c[TOP_W-1];
      cos_r <= apply_sign(neg_c, mag_c);
    end
  end
`endif

endmodule
